// File: rtl/asym_fifo_ctrl.sv
// Byte-in / word-out FIFO controller driving an asymmetric dual-port RAM
// (narrow write port A, wide read port B) with a 2-entry registered output buffer.
module asym_fifo_ctrl #(
  parameter int unsigned WIDTHA     = 8,
  parameter int unsigned WIDTHB     = 32,
  parameter int unsigned ADDRWIDTHA = 8,
  parameter int unsigned ADDRWIDTHB = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTHA-1:0]     wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTHB-1:0]     rd_data,
  output logic [ADDRWIDTHB:0]   level,
  output logic [$clog2(WIDTHB/WIDTHA)-1:0] partial,
  output logic                  ram_enA,
  output logic                  ram_weA,
  output logic [ADDRWIDTHA-1:0] ram_addrA,
  output logic [WIDTHA-1:0]     ram_diA,
  output logic                  ram_enB,
  output logic [ADDRWIDTHB-1:0] ram_addrB,
  input  logic [WIDTHB-1:0]     ram_doB
);

  localparam int unsigned RATIO = WIDTHB / WIDTHA;
  localparam int unsigned LOG2R = $clog2(RATIO);
  localparam int unsigned SIZEA = 2 ** ADDRWIDTHA;
  localparam int unsigned WPW   = ADDRWIDTHA + 1;
  localparam int unsigned RPW   = ADDRWIDTHB + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } seqState_e;

  seqState_e         state, stateNext;
  logic [WPW-1:0]    wrPtr;
  logic [RPW-1:0]    rdPtr;
  logic              readyEn;
  logic [1:0]        bufCnt, bufCntNext;
  logic [WIDTHB-1:0] bufHead, bufHeadNext;
  logic [WIDTHB-1:0] bufTail, bufTailNext;
  logic              rdValidQ;

  logic [WPW-1:0]    byteOcc;
  logic [RPW-1:0]    avail;
  logic [2:0]        slotsUsed;
  logic              full, accept, pop, push, issue, inFlight;

  // Occupancy in bytes; words already handed to port B no longer count.
  assign byteOcc  = wrPtr - {rdPtr, {LOG2R{1'b0}}};
  assign full     = (byteOcc == WPW'(SIZEA));
  assign wr_ready = readyEn && !full && !flush;
  assign accept   = wr_valid && wr_ready;

  assign avail    = wrPtr[ADDRWIDTHA:LOG2R] - rdPtr;
  assign inFlight = (state == FETCH);
  assign pop      = rdValidQ && rd_ready;
  assign push     = inFlight && !flush;

  // A word leaving the buffer this cycle frees its slot, giving 1 word/clk sustained.
  assign slotsUsed = {1'b0, bufCnt} + 3'(inFlight) - 3'(pop);
  assign issue     = !flush && (avail != '0) && (slotsUsed < 3'd2);

  assign ram_enA   = accept;
  assign ram_weA   = accept;
  assign ram_addrA = accept ? wrPtr[ADDRWIDTHA-1:0] : '0;
  assign ram_diA   = accept ? wr_data : '0;
  assign ram_enB   = issue;
  assign ram_addrB = issue ? rdPtr[ADDRWIDTHB-1:0] : '0;

  assign level    = avail;
  assign partial  = wrPtr[LOG2R-1:0];
  assign rd_valid = rdValidQ;
  assign rd_data  = bufHead;

  // Read sequencer: FETCH marks the cycle in which ram_doB carries an issued word.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = issue ? FETCH : IDLE;
      FETCH:   stateNext = issue ? FETCH : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output buffer update: head is the word presented on rd_data.
  always_comb begin
    bufCntNext  = bufCnt;
    bufHeadNext = bufHead;
    bufTailNext = bufTail;
    case ({push, pop})
      2'b10: begin
        if (bufCnt == 2'd0) bufHeadNext = ram_doB;
        else                bufTailNext = ram_doB;
        bufCntNext = bufCnt + 2'd1;
      end
      2'b01: begin
        bufHeadNext = bufTail;
        bufCntNext  = bufCnt - 2'd1;
      end
      2'b11: begin
        if (bufCnt == 2'd1) begin
          bufHeadNext = ram_doB;
        end else begin
          bufHeadNext = bufTail;
          bufTailNext = ram_doB;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wrPtr    <= '0;
      rdPtr    <= '0;
      readyEn  <= 1'b0;
      bufCnt   <= 2'd0;
      bufHead  <= '0;
      bufTail  <= '0;
      rdValidQ <= 1'b0;
    end else begin
      readyEn <= 1'b1;
      if (flush) begin
        state    <= IDLE;
        wrPtr    <= '0;
        rdPtr    <= '0;
        bufCnt   <= 2'd0;
        bufHead  <= '0;
        bufTail  <= '0;
        rdValidQ <= 1'b0;
      end else begin
        state    <= stateNext;
        bufCnt   <= bufCntNext;
        bufHead  <= bufHeadNext;
        bufTail  <= bufTailNext;
        rdValidQ <= (bufCntNext != 2'd0);
        if (accept) wrPtr <= wrPtr + WPW'(1);
        if (issue)  rdPtr <= rdPtr + RPW'(1);
      end
    end
  end

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// Directed bench for asym_fifo_ctrl: vector table for the basic byte-to-word flow,
// hand-written sequences for fill, wrap, flush and asynchronous reset.
module tb_asym_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [6:0]  level;
  logic [1:0]  partial;
  logic        ram_enA, ram_weA;
  logic [7:0]  ram_addrA;
  logic [7:0]  ram_diA;
  logic        ram_enB;
  logic [5:0]  ram_addrB;
  logic [31:0] ram_doB = '0;

  int checks = 0;
  int errors = 0;
  int seq = 0;
  logic [7:0]  byteQ[$];
  logic [31:0] expW;

  asym_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .partial(partial),
    .ram_enA(ram_enA), .ram_weA(ram_weA), .ram_addrA(ram_addrA), .ram_diA(ram_diA),
    .ram_enB(ram_enB), .ram_addrB(ram_addrB), .ram_doB(ram_doB)
  );

  always #5 clk = ~clk;

  // Asymmetric RAM: addrA = {addrB, lane}, registered port B read.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_enA && ram_weA) mem[ram_addrA] <= ram_diA;
    if (ram_enB) ram_doB <= {mem[{ram_addrB, 2'd3}], mem[{ram_addrB, 2'd2}],
                             mem[{ram_addrB, 2'd1}], mem[{ram_addrB, 2'd0}]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every consumed word must be the next 4 accepted bytes, lane 0 first.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      byteQ.delete();
    end else begin
      if (rd_valid && rd_ready) begin
        if (byteQ.size() < 4) begin
          chk("sb underflow", 32'(byteQ.size()), 32'd4);
        end else begin
          expW = {byteQ[3], byteQ[2], byteQ[1], byteQ[0]};
          chk("sb word", rd_data, expW);
          for (int k = 0; k < 4; k++) void'(byteQ.pop_front());
        end
      end
      if (wr_valid && wr_ready) byteQ.push_back(wr_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    #1;
    while (!wr_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!wr_ready) chk("push timeout", 32'(wr_ready), 32'd1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " wr_ready"},  32'(wr_ready),  32'd0);
    chk({tag, " rd_valid"},  32'(rd_valid),  32'd0);
    chk({tag, " rd_data"},   rd_data,        32'd0);
    chk({tag, " level"},     32'(level),     32'd0);
    chk({tag, " partial"},   32'(partial),   32'd0);
    chk({tag, " ram_enA"},   32'(ram_enA),   32'd0);
    chk({tag, " ram_weA"},   32'(ram_weA),   32'd0);
    chk({tag, " ram_addrA"}, 32'(ram_addrA), 32'd0);
    chk({tag, " ram_diA"},   32'(ram_diA),   32'd0);
    chk({tag, " ram_enB"},   32'(ram_enB),   32'd0);
    chk({tag, " ram_addrB"}, 32'(ram_addrB), 32'd0);
  endtask

  typedef struct {
    logic        wv;
    logic [7:0]  wd;
    logic        rv;
    logic [31:0] rdata;
    logic [6:0]  lvl;
    logic [1:0]  part;
    logic        enA;
    logic [7:0]  addrA;
    logic        enB;
    logic [5:0]  addrB;
  } vec_t;

  function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic rv,
                              input logic [31:0] rdata, input logic [6:0] lvl,
                              input logic [1:0] part, input logic enA, input logic [7:0] addrA,
                              input logic enB, input logic [5:0] addrB);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rv = rv; v.rdata = rdata; v.lvl = lvl;
    v.part = part; v.enA = enA; v.addrA = addrA; v.enB = enB; v.addrB = addrB;
    return v;
  endfunction

  localparam int NV = 21;
  vec_t vecs [NV];

  initial begin
    int acc, pops, words;
    string nm;

    // 8 bytes with rd_ready=1, then a 3-byte partial word completed later.
    vecs[0]  = mk(1, 8'h01, 0, 32'h0,        7'd0, 2'd0, 1, 8'd0,  0, 6'd0);
    vecs[1]  = mk(1, 8'h02, 0, 32'h0,        7'd0, 2'd1, 1, 8'd1,  0, 6'd0);
    vecs[2]  = mk(1, 8'h03, 0, 32'h0,        7'd0, 2'd2, 1, 8'd2,  0, 6'd0);
    vecs[3]  = mk(1, 8'h04, 0, 32'h0,        7'd0, 2'd3, 1, 8'd3,  0, 6'd0);
    vecs[4]  = mk(1, 8'h05, 0, 32'h0,        7'd1, 2'd0, 1, 8'd4,  1, 6'd0);
    vecs[5]  = mk(1, 8'h06, 0, 32'h0,        7'd0, 2'd1, 1, 8'd5,  0, 6'd0);
    vecs[6]  = mk(1, 8'h07, 1, 32'h04030201, 7'd0, 2'd2, 1, 8'd6,  0, 6'd0);
    vecs[7]  = mk(1, 8'h08, 0, 32'h0,        7'd0, 2'd3, 1, 8'd7,  0, 6'd0);
    vecs[8]  = mk(0, 8'h00, 0, 32'h0,        7'd1, 2'd0, 0, 8'd0,  1, 6'd1);
    vecs[9]  = mk(0, 8'h00, 0, 32'h0,        7'd0, 2'd0, 0, 8'd0,  0, 6'd0);
    vecs[10] = mk(0, 8'h00, 1, 32'h08070605, 7'd0, 2'd0, 0, 8'd0,  0, 6'd0);
    vecs[11] = mk(1, 8'h11, 0, 32'h0,        7'd0, 2'd0, 1, 8'd8,  0, 6'd0);
    vecs[12] = mk(1, 8'h22, 0, 32'h0,        7'd0, 2'd1, 1, 8'd9,  0, 6'd0);
    vecs[13] = mk(1, 8'h33, 0, 32'h0,        7'd0, 2'd2, 1, 8'd10, 0, 6'd0);
    vecs[14] = mk(0, 8'h00, 0, 32'h0,        7'd0, 2'd3, 0, 8'd0,  0, 6'd0);
    vecs[15] = mk(0, 8'h00, 0, 32'h0,        7'd0, 2'd3, 0, 8'd0,  0, 6'd0);
    vecs[16] = mk(1, 8'h44, 0, 32'h0,        7'd0, 2'd3, 1, 8'd11, 0, 6'd0);
    vecs[17] = mk(0, 8'h00, 0, 32'h0,        7'd1, 2'd0, 0, 8'd0,  1, 6'd2);
    vecs[18] = mk(0, 8'h00, 0, 32'h0,        7'd0, 2'd0, 0, 8'd0,  0, 6'd0);
    vecs[19] = mk(0, 8'h00, 1, 32'h44332211, 7'd0, 2'd0, 0, 8'd0,  0, 6'd0);
    vecs[20] = mk(0, 8'h00, 0, 32'h0,        7'd0, 2'd0, 0, 8'd0,  0, 6'd0);

    rst_n = 1'b0; flush = 1'b0; rd_ready = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hAA;
    #2;
    chk_reset("reset");
    wr_valid = 1'b0;
    #10;
    rst_n = 1'b1;
    #1;
    chk("post-release wr_ready", 32'(wr_ready), 32'd0);
    tick;

    // Table-driven byte-to-word flow.
    rd_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      wr_valid = vecs[i].wv;
      wr_data  = vecs[i].wd;
      #1;
      nm = $sformatf("row%0d", i);
      chk({nm, " wr_ready"},  32'(wr_ready),  32'd1);
      chk({nm, " rd_valid"},  32'(rd_valid),  32'(vecs[i].rv));
      if (vecs[i].rv) chk({nm, " rd_data"}, rd_data, vecs[i].rdata);
      chk({nm, " level"},     32'(level),     32'(vecs[i].lvl));
      chk({nm, " partial"},   32'(partial),   32'(vecs[i].part));
      chk({nm, " ram_enA"},   32'(ram_enA),   32'(vecs[i].enA));
      chk({nm, " ram_weA"},   32'(ram_weA),   32'(vecs[i].enA));
      chk({nm, " ram_addrA"}, 32'(ram_addrA), 32'(vecs[i].addrA));
      if (vecs[i].enA) chk({nm, " ram_diA"}, 32'(ram_diA), 32'(vecs[i].wd));
      chk({nm, " ram_enB"},   32'(ram_enB),   32'(vecs[i].enB));
      chk({nm, " ram_addrB"}, 32'(ram_addrB), 32'(vecs[i].addrB));
      tick;
    end

    // Fill with rd_ready=0: 2 words prefetch into the buffer, so 264 bytes fit.
    rd_ready = 1'b0;
    seq = 0;
    for (int i = 0; i < 256; i++) begin
      push_byte(8'(seq));
      seq++;
    end
    tick; tick; tick;
    chk("fill level62",   32'(level),    32'd62);
    chk("fill wr_ready",  32'(wr_ready), 32'd1);
    chk("fill rd_valid",  32'(rd_valid), 32'd1);
    chk("fill rd_data",   rd_data,       32'h03020100);
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(seq);
      #1;
      if (wr_ready) begin
        seq++;
        acc++;
      end
      tick;
    end
    wr_valid = 1'b0;
    #1;
    chk("extra bytes",    32'(acc),      32'd8);
    chk("full level64",   32'(level),    32'd64);
    chk("full wr_ready",  32'(wr_ready), 32'd0);
    chk("full partial",   32'(partial),  32'd0);

    // Continuous read/write from full, wrapping the pointers.
    acc = 0;
    pops = 0;
    for (int c = 0; c < 1000; c++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(seq);
      rd_ready = 1'b1;
      #1;
      if (wr_ready) begin
        seq++;
        acc++;
      end
      if (c >= 600 && rd_valid) pops++;
      tick;
    end
    wr_valid = 1'b0;
    chk("stream bytes>=995", 32'(acc >= 995), 32'd1);
    chk("stream 1w/4B", 32'(pops >= 99 && pops <= 101), 32'd1);
    for (int c = 0; c < 20; c++) tick;
    chk("drain rd_valid", 32'(rd_valid), 32'd0);
    chk("drain level",    32'(level),    32'd0);
    chk("drain leftover", 32'(byteQ.size()), 32'(partial));

    // Flush with a buffered word, an in-flight read, a stored word and 2 partial bytes.
    rd_ready = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    for (int i = 0; i < 18; i++) push_byte(8'hA0 + 8'(i));
    tick; tick; tick; tick;
    chk("pre level",    32'(level),    32'd2);
    chk("pre partial",  32'(partial),  32'd2);
    chk("pre rd_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    #1;
    chk("pop-credit issue", 32'(ram_enB),   32'd1);
    chk("pop-credit addr",  32'(ram_addrB), 32'd2);
    tick;
    rd_ready = 1'b0;
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h55;
    #1;
    chk("flush-cycle wr_ready", 32'(wr_ready), 32'd0);
    chk("flush-cycle ram_enA",  32'(ram_enA),  32'd0);
    chk("flush-cycle level",    32'(level),    32'd1);
    chk("flush-cycle rd_valid", 32'(rd_valid), 32'd1);
    tick;
    flush = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("flushed rd_valid", 32'(rd_valid), 32'd0);
    chk("flushed level",    32'(level),    32'd0);
    chk("flushed partial",  32'(partial),  32'd0);
    chk("flushed rd_data",  rd_data,       32'd0);
    chk("flushed wr_ready", 32'(wr_ready), 32'd1);
    tick; tick; tick;
    chk("flushed no stale", 32'(rd_valid), 32'd0);
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_byte(8'hC0 + 8'(i));
    words = 0;
    for (int c = 0; c < 10; c++) begin
      if (rd_valid) begin
        chk("post-flush word", rd_data, 32'hC4C3C2C1);
        words++;
      end
      tick;
    end
    chk("post-flush count", 32'(words), 32'd1);

    // Asynchronous reset pulse mid-stream.
    for (int c = 0; c < 12; c++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(seq);
      #1;
      if (wr_ready) seq++;
      tick;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wr_valid = 1'b0;
    #1;
    chk("async release wr_ready", 32'(wr_ready), 32'd0);
    tick;
    chk("resume wr_ready", 32'(wr_ready), 32'd1);
    for (int i = 1; i <= 4; i++) push_byte(8'hD0 + 8'(i));
    words = 0;
    for (int c = 0; c < 10; c++) begin
      if (rd_valid) begin
        chk("resume word", rd_data, 32'hD4D3D2D1);
        words++;
      end
      tick;
    end
    chk("resume count", 32'(words), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
